scanning_mux: RTL

SCANNING_MUX -- requirements
Module: scanning_mux

---
 rtl/scanning_mux.sv | 120 ++++++++++++
 1 files changed

// File: rtl/scanning_mux.sv
// Manual/round-robin channel sampler; sample valid two edges after Enable_In launch, held under Ready_In=0.
// SCANNING_MUX_TRISTATE_EN: MUX_Data_Out floats (instead of driving 0) while Enable_In is low.
module scanning_mux #(
   parameter int DATA_WIDTH   = 8,
   parameter int NUM_CHANNELS = 8,
   localparam int SEL_WIDTH   = $clog2(NUM_CHANNELS)
) (
   input  logic                               Clock_In,
   input  logic                               Reset_N_In,
   input  logic                               Enable_In,
   input  logic                               Mode_In,
   input  logic [SEL_WIDTH-1:0]               Select_In,
   input  logic [7:0]                         Dwell_In,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] Data_In,
   input  logic                               Ready_In,
   output logic [DATA_WIDTH-1:0]              MUX_Data_Out,
   output logic [SEL_WIDTH-1:0]               Channel_Out,
   output logic                               Valid_Out,
   output logic                               Error_Out
);

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_PRESENT, S_DWELL} state_t;

   localparam logic [SEL_WIDTH-1:0] LAST_CH  = SEL_WIDTH'(NUM_CHANNELS - 1);
   localparam logic [SEL_WIDTH:0]   NUM_CH_W = (SEL_WIDTH + 1)'(NUM_CHANNELS);

   state_t                r_state;
   state_t                w_next;
   logic [SEL_WIDTH-1:0]  r_ptr;
   logic [7:0]            r_cnt;
   logic [DATA_WIDTH-1:0] r_data;
   logic [SEL_WIDTH-1:0]  r_chan;
   logic                  r_err;
   logic                  r_mode;
   logic                  w_advance;
   logic                  w_load;
   logic [SEL_WIDTH-1:0]  w_idx;
   logic                  w_oob;
   logic [DATA_WIDTH-1:0] w_chan;

   assign w_idx = Mode_In ? r_ptr : Select_In;
   assign w_oob = !Mode_In && ({1'b0, Select_In} >= NUM_CH_W);

   always_comb begin
      w_chan = '0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         if (w_idx == SEL_WIDTH'(k)) w_chan = Data_In[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      w_next    = r_state;
      w_advance = 1'b0;
      w_load    = 1'b0;
      case (r_state)
         S_IDLE:    w_next = S_CAPTURE;
         S_CAPTURE: w_next = S_PRESENT;
         S_PRESENT: begin
            if (Ready_In) begin
               if (!r_mode || Dwell_In == 8'd0) begin
                  w_next    = S_CAPTURE;
                  w_advance = r_mode;
               end else begin
                  w_next = S_DWELL;
                  w_load = 1'b1;
               end
            end
         end
         S_DWELL: begin
            if (r_cnt <= 8'd1) begin
               w_next    = S_CAPTURE;
               w_advance = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
      // Disable wins over everything, including a same-edge handshake.
      if (!Enable_In) begin
         w_next    = S_IDLE;
         w_advance = 1'b0;
         w_load    = 1'b0;
      end
   end

   always_ff @(posedge Clock_In or negedge Reset_N_In) begin
      if (!Reset_N_In) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_cnt   <= '0;
         r_data  <= '0;
         r_chan  <= '0;
         r_err   <= 1'b0;
         r_mode  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_advance) r_ptr <= (r_ptr == LAST_CH) ? '0 : r_ptr + SEL_WIDTH'(1);
         if (w_load) r_cnt <= Dwell_In;
         else if (r_state == S_DWELL && r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
         if (!Enable_In) begin
            r_err <= 1'b0;
         end else if (r_state == S_CAPTURE) begin
            r_mode <= Mode_In;
            r_chan <= w_idx;
            r_data <= w_oob ? '0 : w_chan;
            r_err  <= w_oob;
         end
      end
   end

   assign Valid_Out   = (r_state == S_PRESENT) && Enable_In;
   assign Channel_Out = r_chan;
   assign Error_Out   = r_err;

`ifdef SCANNING_MUX_TRISTATE_EN
   assign MUX_Data_Out = Enable_In ? r_data : {DATA_WIDTH{1'bz}};
`else
   assign MUX_Data_Out = Enable_In ? r_data : '0;
`endif

endmodule
